// File: rtl/scoreboard_pkg.sv
// Shared scoreboard types: BCD digit, 7-segment pattern {g,f,e,d,c,b,a}, segment
// constants and default sizing for the score counter.
package scoreboard_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam int unsigned DEFAULT_MAX_SCORE      = 99;
    localparam int unsigned DEFAULT_REFRESH_CYCLES = 1000;

endpackage

// File: rtl/score_counter_if.sv
// Request/score/display bundle between the pushbutton processor, score_counter and the
// display driver. The slave modport is the score_counter side.
interface score_counter_if;
    import scoreboard_pkg::*;

    logic count_up;
    logic count_down;
    bcd_t score_tens_o;
    bcd_t score_ones_o;
    seg_t seg_o;
    logic digit_sel_o;
    logic changed_o;

    modport master (
        output count_up,
        output count_down,
        input  score_tens_o,
        input  score_ones_o,
        input  seg_o,
        input  digit_sel_o,
        input  changed_o
    );

    modport slave (
        input  count_up,
        input  count_down,
        output score_tens_o,
        output score_ones_o,
        output seg_o,
        output digit_sel_o,
        output changed_o
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; codes above 9 show a blank digit.
module bcd_to_7seg
    import scoreboard_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_counter.sv
// Two-digit BCD score counter with edge-detected up/down requests and a multiplexed
// 7-segment output. Define SCORE_WRAP_EN to wrap at the bounds instead of saturating.
module score_counter
    import scoreboard_pkg::*;
#(
    parameter int unsigned MAX_SCORE      = DEFAULT_MAX_SCORE,
    parameter int unsigned REFRESH_CYCLES = DEFAULT_REFRESH_CYCLES
) (
    input logic            clk_1mhz,
    input logic            rst_n,
    score_counter_if.slave sc
);

    localparam int unsigned CntW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_CYCLES - 1);
    localparam bcd_t MaxTens = bcd_t'(MAX_SCORE / 10);
    localparam bcd_t MaxOnes = bcd_t'(MAX_SCORE % 10);

    logic            up_prev_q, down_prev_q;
    logic            up_evt, down_evt;
    bcd_t            tens_q, tens_d;
    bcd_t            ones_q, ones_d;
    logic            changed_q, changed_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sel_q, sel_d;
    seg_t            seg_q, seg_d;
    bcd_t            digit_next;
    seg_t            seg_dec;
    logic            at_max, at_zero;

    // State registers
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            tens_q      <= '0;
            ones_q      <= '0;
            changed_q   <= 1'b0;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            seg_q       <= SEG_0;
        end else begin
            up_prev_q   <= sc.count_up;
            down_prev_q <= sc.count_down;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            changed_q   <= changed_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign up_evt   = sc.count_up & ~up_prev_q;
    assign down_evt = sc.count_down & ~down_prev_q;
    assign at_max   = (tens_q == MaxTens) && (ones_q == MaxOnes);
    assign at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Next score: simultaneous up and down events cancel out
    always_comb begin
        tens_d    = tens_q;
        ones_d    = ones_q;
        changed_d = 1'b0;
        if (up_evt && !down_evt) begin
            if (at_max) begin
`ifdef SCORE_WRAP_EN
                tens_d    = 4'd0;
                ones_d    = 4'd0;
                changed_d = 1'b1;
`endif
            end else begin
                changed_d = 1'b1;
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end
        end else if (down_evt && !up_evt) begin
            if (at_zero) begin
`ifdef SCORE_WRAP_EN
                tens_d    = MaxTens;
                ones_d    = MaxOnes;
                changed_d = 1'b1;
`endif
            end else begin
                changed_d = 1'b1;
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    // Refresh counter and digit select; segments decode next-state values so that
    // select and segments always move on the same edge.
    always_comb begin
        cnt_d      = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        sel_d      = (cnt_q == CntLast) ? ~sel_q : sel_q;
        digit_next = sel_d ? tens_d : ones_d;
        seg_d      = (sel_d && (tens_d == 4'd0)) ? SEG_BLANK : seg_dec;
    end

    bcd_to_7seg u_dec (
        .bcd (digit_next),
        .seg (seg_dec)
    );

    assign sc.score_tens_o = tens_q;
    assign sc.score_ones_o = ones_q;
    assign sc.seg_o        = seg_q;
    assign sc.digit_sel_o  = sel_q;
    assign sc.changed_o    = changed_q;

endmodule
